uart_tx: RTL and testbench

UART transmitter serializing one character per request onto the `tx` line. It is the transmit-side counterpart of the block's receive path and shares that path's configuration fields and 16x oversampling tick. Frames are 5–8 data bits, LSB first, with optional parity and 1 or 2 stop bits. Transmission is gated by the peer's `cts_n` flow-control input; the APB register block drives it.

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Character handshake between the APB register block and the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data_i;
  logic       start_tx_i;
  logic       tx_busy_o;
  logic       tx_done_o;

  modport master (output tx_data_i, output start_tx_i, input tx_busy_o, input tx_done_o);
  modport slave  (input tx_data_i, input start_tx_i, output tx_busy_o, output tx_done_o);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits LSB first, optional parity, 1/2 stop bits,
// paced by a 16x tx_tick and gated by cts_n at frame acceptance.
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_tick,
  input  logic [1:0] data_bit_num_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  input  logic       stop_bit_num_i,
  input  logic       cts_n,
  uart_tx_if.slave   bus,
  output logic       tx
);

  // state     | meaning
  // TX_IDLE   | line high, waiting for start_tx_i with cts_n low
  // TX_START  | start bit (low)
  // TX_DATA   | data bits, LSB first
  // TX_PARITY | parity bit
  // TX_STOP   | one or two stop bits (high)
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [1:0] nbits_q, nbits_d;
  logic       par_en_q, par_en_d;
  logic       par_q, par_d;
  logic       stop2_q, stop2_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_d, busy_d, done_d;
  logic       busy_q, done_q;

  logic       bit_end;
  logic [2:0] last_idx;
  logic [7:0] width_mask;
  logic       par_even;

  assign bit_end  = tx_tick && (tick_q == 4'd15);
  assign last_idx = {1'b0, nbits_q} + 3'd4;

  always_comb begin
    case (data_bit_num_i)
      2'd0:    width_mask = 8'h1F;
      2'd1:    width_mask = 8'h3F;
      2'd2:    width_mask = 8'h7F;
      default: width_mask = 8'hFF;
    endcase
  end

  assign par_even = ^(bus.tx_data_i & width_mask);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    nbits_d  = nbits_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    done_d   = 1'b0;

    // The counter wraps 15 -> 0 on its own, so bit boundaries need no reload.
    if (state_q != TX_IDLE && tx_tick)
      tick_d = tick_q + 4'd1;

    case (state_q)
      TX_IDLE: begin
        if (bus.start_tx_i && !cts_n) begin
          state_d  = TX_START;
          data_d   = bus.tx_data_i;
          nbits_d  = data_bit_num_i;
          par_en_d = parity_en_i;
          par_d    = parity_type_i ? par_even : ~par_even;
          stop2_d  = stop_bit_num_i;
          tick_d   = 4'd0;
          bit_d    = 3'd0;
        end
      end
      TX_START: begin
        if (bit_end)
          state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == last_idx) begin
            bit_d   = 3'd0;
            state_d = par_en_q ? TX_PARITY : TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end)
          state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop2_q && bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else begin
            bit_d   = 3'd0;
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level follows the next state so tx is a clean register output.
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = data_d[bit_d];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      data_q   <= 8'd0;
      nbits_q  <= 2'd0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      tx       <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      nbits_q  <= nbits_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      tx       <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx_busy_o = busy_q;
  assign bus.tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed plus randomized bench for uart_tx against a bit-list frame model.
module tb_uart_tx;
  logic       clk;
  logic       rst;
  logic       tx_tick;
  logic [1:0] data_bit_num_i;
  logic       parity_en_i;
  logic       parity_type_i;
  logic       stop_bit_num_i;
  logic       cts_n;
  logic       tx;

  uart_tx_if bus_if ();

  uart_tx dut (
    .clk            (clk),
    .rst            (rst),
    .tx_tick        (tx_tick),
    .data_bit_num_i (data_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .cts_n          (cts_n),
    .bus            (bus_if),
    .tx             (tx)
  );

  int errors = 0;
  int checks = 0;
  int tick_per = 1;
  int tick_ph = 0;
  int last_cyc = 0;
  bit exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick pattern changes only on the falling edge, away from the DUT's sampling edge.
  initial begin
    tx_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_ph++;
      tx_tick = ((tick_ph % tick_per) == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit time.
  task automatic build_exp(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                           input logic pt, input logic sb);
    int n;
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    n = int'(nb) + 5;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back(pt ? bit'(ones % 2) : bit'(1 - ones % 2));
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endtask

  task automatic setup(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                       input logic pt, input logic sb);
    bus_if.tx_data_i = d;
    data_bit_num_i   = nb;
    parity_en_i      = pe;
    parity_type_i    = pt;
    stop_bit_num_i   = sb;
    build_exp(d, nb, pe, pt, sb);
  endtask

  // Follows one frame from its acceptance edge. mode 1: raise cts_n mid-frame;
  // mode 2: scramble data and pulse start mid-frame. hold keeps start_tx_i high.
  task automatic track_frame(input int mode, input bit hold);
    int ticks;
    int cyc;
    int total;
    int lim;
    total = exp_q.size() * 16;
    lim = total * tick_per + 50;
    @(posedge clk);
    #1;
    chk("accept_tx", tx, 0);
    chk("accept_busy", bus_if.tx_busy_o, 1);
    chk("accept_done", bus_if.tx_done_o, 0);
    if (!hold) bus_if.start_tx_i = 1'b0;
    ticks = 0;
    cyc = 0;
    while (ticks < total && cyc < lim) begin
      @(posedge clk);
      if (tx_tick) ticks++;
      cyc++;
      #1;
      if (ticks < total) begin
        chk("tx_bit", tx, exp_q[ticks / 16]);
        chk("busy_mid", bus_if.tx_busy_o, 1);
        chk("done_mid", bus_if.tx_done_o, 0);
      end
      if (mode == 1 && cyc == 30) cts_n = 1'b1;
      if (mode == 2 && cyc == 20) begin
        bus_if.tx_data_i  = ~bus_if.tx_data_i;
        bus_if.start_tx_i = 1'b1;
      end
      if (mode == 2 && cyc == 21 && !hold) bus_if.start_tx_i = 1'b0;
    end
    last_cyc = cyc;
    chk("frame_ticks", ticks, total);
    chk("end_done", bus_if.tx_done_o, 1);
    chk("end_busy", bus_if.tx_busy_o, 0);
    chk("end_tx", tx, 1);
    chk("frame_cycles", (cyc >= (total - 1) * tick_per + 1) && (cyc <= total * tick_per), 1);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk("done_one_cycle", bus_if.tx_done_o, 0);
      chk("idle_busy", bus_if.tx_busy_o, 0);
      chk("idle_tx", tx, 1);
    end
  endtask

  initial begin
    logic [7:0] rd;
    rst = 1'b0;
    cts_n = 1'b1;
    bus_if.start_tx_i = 1'b0;
    setup(8'h00, 2'd3, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", bus_if.tx_busy_o, 0);
    chk("rst_done", bus_if.tx_done_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 8N1 0x55, tick every clock
    @(negedge clk);
    tick_per = 1;
    setup(8'h55, 2'd3, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b0;
    bus_if.start_tx_i = 1'b1;
    track_frame(0, 1'b0);
    chk("done_at_160", last_cyc, 160);

    // 5-bit even parity 0x13
    @(negedge clk);
    setup(8'h13, 2'd0, 1'b1, 1'b1, 1'b0);
    bus_if.start_tx_i = 1'b1;
    track_frame(0, 1'b0);
    chk("e5_bit_times", exp_q.size(), 8);

    // 8-bit odd parity, two stops 0xA5, tick every 4th clock
    @(negedge clk);
    tick_per = 4;
    setup(8'hA5, 2'd3, 1'b1, 1'b0, 1'b1);
    bus_if.start_tx_i = 1'b1;
    track_frame(0, 1'b0);
    chk("o8_bit_times", exp_q.size(), 12);
    tick_per = 1;

    // Flow control: blocked by cts_n, released, then cts_n raised mid-frame
    @(negedge clk);
    setup(8'h3C, 2'd2, 1'b1, 1'b0, 1'b0);
    cts_n = 1'b1;
    bus_if.start_tx_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("cts_hold_tx", tx, 1);
      chk("cts_hold_busy", bus_if.tx_busy_o, 0);
    end
    @(negedge clk);
    cts_n = 1'b0;
    track_frame(1, 1'b0);

    // Mid-frame data change and start pulse are ignored
    @(negedge clk);
    cts_n = 1'b0;
    tick_per = 2;
    setup(8'hC3, 2'd3, 1'b0, 1'b0, 1'b1);
    bus_if.start_tx_i = 1'b1;
    track_frame(2, 1'b0);

    // Back-to-back with start held high; second frame carries the changed data
    @(negedge clk);
    tick_per = 1;
    setup(8'h9A, 2'd1, 1'b1, 1'b1, 1'b0);
    bus_if.start_tx_i = 1'b1;
    track_frame(2, 1'b1);
    build_exp(bus_if.tx_data_i, data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i);
    track_frame(0, 1'b0);

    // Reset during the data bits
    @(negedge clk);
    setup(8'hF0, 2'd3, 1'b0, 1'b0, 1'b0);
    bus_if.start_tx_i = 1'b1;
    @(posedge clk);
    #1 bus_if.start_tx_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus_if.tx_busy_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", bus_if.tx_busy_o, 0);
    chk("async_rst_done", bus_if.tx_done_o, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_done", bus_if.tx_done_o, 0);
      chk("rst_hold_tx", tx, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    setup(8'h6B, 2'd3, 1'b1, 1'b1, 1'b1);
    bus_if.start_tx_i = 1'b1;
    track_frame(0, 1'b0);

    // Random formats, data and tick rates
    for (int n = 0; n < 14; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      @(negedge clk);
      tick_per = int'($urandom_range(1, 3));
      rd = 8'($urandom);
      setup(rd, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      bus_if.start_tx_i = 1'b1;
      track_frame(0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
